// File: rtl/forward_ctrl.sv
// Operand-forwarding select, load-use detection and single-entry mult/div scoreboard.
// Optional macro FWD_STALL_STATS_EN adds a saturating 32-bit stall cycle counter (stall_cnt).
module forward_ctrl #(
    parameter  int REG_AW = 5,
    parameter  int NSTG   = 2,
    localparam int SELW   = $clog2(NSTG + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dx_valid,
    input  logic [REG_AW-1:0]        dx_rs_a,
    input  logic [REG_AW-1:0]        dx_rs_b,
    input  logic                     dx_is_md,
    input  logic [REG_AW-1:0]        dx_md_rd,
    input  logic [NSTG*REG_AW-1:0]   stg_rd,
    input  logic [NSTG-1:0]          stg_we,
    input  logic                     stg_lw,
    input  logic                     md_ready,
    output logic [SELW-1:0]          sel_a,
    output logic [SELW-1:0]          sel_b,
    output logic                     stall,
`ifdef FWD_STALL_STATS_EN
    output logic [31:0]              stall_cnt,
`endif
    output logic                     md_busy
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e          state_q;
    md_state_e          state_d;
    logic [REG_AW-1:0]  md_dest_q;
    logic [REG_AW-1:0]  md_dest_d;
    logic [NSTG-1:0]    hit_a_s;
    logic [NSTG-1:0]    hit_b_s;
    logic               load_use_s;
    logic               md_raw_s;
    logic               md_hazard_s;
    logic               stall_s;
    logic               issue_s;

    // Register 0 is hard-wired, so it can never produce a dependency.
    function automatic logic src_hit(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rd);
        return (rs != {REG_AW{1'b0}}) && (rs == rd);
    endfunction

    // Per-stage producer match for each operand.
    always_comb begin
        hit_a_s = {NSTG{1'b0}};
        hit_b_s = {NSTG{1'b0}};
        for (int k = 0; k < NSTG; k++) begin
            hit_a_s[k] = stg_we[k] && src_hit(dx_rs_a, stg_rd[k*REG_AW +: REG_AW]);
            hit_b_s[k] = stg_we[k] && src_hit(dx_rs_b, stg_rd[k*REG_AW +: REG_AW]);
        end
    end

    // Priority select: scanning from the far stage inward lets the nearest match win.
    always_comb begin
        sel_a = {SELW{1'b0}};
        sel_b = {SELW{1'b0}};
        for (int k = NSTG - 1; k >= 0; k--) begin
            sel_a = hit_a_s[k] ? SELW'(k + 1) : sel_a;
            sel_b = hit_b_s[k] ? SELW'(k + 1) : sel_b;
        end
    end

    // Hazard detection; a completing mult/div (md_ready) releases every scoreboard stall.
    always_comb begin
        load_use_s  = dx_valid && stg_lw && stg_we[0] &&
                      (src_hit(dx_rs_a, stg_rd[REG_AW-1:0]) || src_hit(dx_rs_b, stg_rd[REG_AW-1:0]));
        md_raw_s    = src_hit(dx_rs_a, md_dest_q) || src_hit(dx_rs_b, md_dest_q);
        md_hazard_s = (state_q == MD_BUSY) && !md_ready && dx_valid && (md_raw_s || dx_is_md);
        stall_s     = load_use_s || md_hazard_s;
        issue_s     = dx_valid && dx_is_md && !stall_s;
    end

    // Scoreboard next-state.
    always_comb begin
        state_d   = state_q;
        md_dest_d = md_dest_q;
        case (state_q)
            MD_IDLE: begin
                if (issue_s) begin
                    state_d   = MD_BUSY;
                    md_dest_d = dx_md_rd;
                end else begin
                    state_d   = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (md_ready && issue_s) begin
                    state_d   = MD_BUSY;
                    md_dest_d = dx_md_rd;
                end else if (md_ready) begin
                    state_d   = MD_IDLE;
                end else begin
                    state_d   = MD_BUSY;
                end
            end
            default: begin
                state_d   = MD_IDLE;
                md_dest_d = {REG_AW{1'b0}};
            end
        endcase
    end

    // Scoreboard state; reset abandons any outstanding mult/div.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= MD_IDLE;
            md_dest_q <= {REG_AW{1'b0}};
        end else begin
            state_q   <= state_d;
            md_dest_q <= md_dest_d;
        end
    end

    assign stall   = stall_s;
    assign md_busy = (state_q == MD_BUSY);

`ifdef FWD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Saturating count of stalled clock edges.
    always_comb begin
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed self-checking bench for forward_ctrl (NSTG=2, REG_AW=5); expectations queued per step.
// Exercises the stall counter when FWD_STALL_STATS_EN is defined.
module tb_forward_ctrl;
    localparam int REG_AW = 5;
    localparam int NSTG   = 2;
    localparam int SELW   = 2;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   dx_valid;
    logic [REG_AW-1:0]      dx_rs_a;
    logic [REG_AW-1:0]      dx_rs_b;
    logic                   dx_is_md;
    logic [REG_AW-1:0]      dx_md_rd;
    logic [NSTG*REG_AW-1:0] stg_rd;
    logic [NSTG-1:0]        stg_we;
    logic                   stg_lw;
    logic                   md_ready;
    logic [SELW-1:0]        sel_a;
    logic [SELW-1:0]        sel_b;
    logic                   stall;
    logic                   md_busy;
`ifdef FWD_STALL_STATS_EN
    logic [31:0]            stall_cnt;
`endif

    typedef struct {
        string           tag;
        logic [SELW-1:0] sa;
        logic [SELW-1:0] sb;
        logic            st;
        logic            bsy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    forward_ctrl #(.REG_AW(REG_AW), .NSTG(NSTG)) dut (
        .clock    (clock),
        .reset    (reset),
        .dx_valid (dx_valid),
        .dx_rs_a  (dx_rs_a),
        .dx_rs_b  (dx_rs_b),
        .dx_is_md (dx_is_md),
        .dx_md_rd (dx_md_rd),
        .stg_rd   (stg_rd),
        .stg_we   (stg_we),
        .stg_lw   (stg_lw),
        .md_ready (md_ready),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .stall    (stall),
`ifdef FWD_STALL_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .md_busy  (md_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp({e.tag, ".sel_a"},   32'(sel_a),   32'(e.sa));
            cmp({e.tag, ".sel_b"},   32'(sel_b),   32'(e.sb));
            cmp({e.tag, ".stall"},   32'(stall),   32'(e.st));
            cmp({e.tag, ".md_busy"}, 32'(md_busy), 32'(e.bsy));
        end
    endtask

    task automatic expect_out(input string tag, input logic [SELW-1:0] sa, input logic [SELW-1:0] sb,
                              input logic st, input logic bsy);
        exp_t e;
        e.tag = tag; e.sa = sa; e.sb = sb; e.st = st; e.bsy = bsy;
        exp_q.push_back(e);
    endtask

    // Queue expectations for the currently driven inputs, check mid-cycle, then cross one edge.
    task automatic step(input string tag, input logic [SELW-1:0] sa, input logic [SELW-1:0] sb,
                        input logic st, input logic bsy);
        expect_out(tag, sa, sb, st, bsy);
        @(negedge clock);
        check_all();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        dx_valid = 1'b0; dx_rs_a = 5'd0; dx_rs_b = 5'd0; dx_is_md = 1'b0; dx_md_rd = 5'd0;
        stg_rd = 10'd0; stg_we = 2'b00; stg_lw = 1'b0; md_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        @(posedge clock);
        #1;
        // In reset: load-use still stalls, mult/div issue is never captured.
        dx_valid = 1'b1; stg_lw = 1'b1; stg_we = 2'b01; stg_rd = {5'd0, 5'd7}; dx_rs_a = 5'd7;
        dx_is_md = 1'b1; dx_md_rd = 5'd5;
        step("rst_load_use", 2'd1, 2'd0, 1'b1, 1'b0);
        stg_lw = 1'b0;
        step("rst_no_issue", 2'd1, 2'd0, 1'b0, 1'b0);
`ifdef FWD_STALL_STATS_EN
        cmp("rst_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b1;
        clear_in();
        step("post_reset", 2'd0, 2'd0, 1'b0, 1'b0);

        // Forwarding priority
        dx_valid = 1'b1; dx_rs_a = 5'd3; stg_rd = {5'd3, 5'd3}; stg_we = 2'b11;
        step("fwd_near", 2'd1, 2'd0, 1'b0, 1'b0);
        stg_we = 2'b10;
        step("fwd_far", 2'd2, 2'd0, 1'b0, 1'b0);
        dx_rs_a = 5'd5; dx_rs_b = 5'd6; stg_rd = {5'd6, 5'd5}; stg_we = 2'b11;
        step("fwd_ab", 2'd1, 2'd2, 1'b0, 1'b0);
        stg_we = 2'b00;
        step("no_we", 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        dx_valid = 1'b1; stg_rd = {5'd0, 5'd0}; stg_we = 2'b01; stg_lw = 1'b1;
        step("zero_src", 2'd0, 2'd0, 1'b0, 1'b0);

        // Load-use
        clear_in();
        dx_valid = 1'b1; stg_lw = 1'b1; stg_we = 2'b01; stg_rd = {5'd0, 5'd7}; dx_rs_a = 5'd7;
        step("load_use", 2'd1, 2'd0, 1'b1, 1'b0);
        stg_lw = 1'b0; stg_we = 2'b10; stg_rd = {5'd7, 5'd0};
        step("load_adv", 2'd2, 2'd0, 1'b0, 1'b0);
        clear_in();
        stg_lw = 1'b1; stg_we = 2'b01; stg_rd = {5'd0, 5'd7}; dx_rs_b = 5'd7;
        step("lu_invalid", 2'd0, 2'd1, 1'b0, 1'b0);

        // Mult/div RAW held until md_ready
        clear_in();
        dx_valid = 1'b1; dx_is_md = 1'b1; dx_md_rd = 5'd9;
        step("md_issue", 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        dx_valid = 1'b1; dx_rs_b = 5'd9;
        step("md_raw1", 2'd0, 2'd0, 1'b1, 1'b1);
        step("md_raw2", 2'd0, 2'd0, 1'b1, 1'b1);
        md_ready = 1'b1;
        step("md_ready", 2'd0, 2'd0, 1'b0, 1'b1);
        md_ready = 1'b0;
        step("md_done", 2'd0, 2'd0, 1'b0, 1'b0);

        // Back-to-back mult/div with md_ready
        clear_in();
        dx_valid = 1'b1; dx_is_md = 1'b1; dx_md_rd = 5'd9;
        step("md_issue2", 2'd0, 2'd0, 1'b0, 1'b0);
        dx_md_rd = 5'd12; dx_rs_a = 5'd1;
        step("md_struct", 2'd0, 2'd0, 1'b1, 1'b1);
        md_ready = 1'b1; dx_rs_a = 5'd9;
        step("md_b2b", 2'd0, 2'd0, 1'b0, 1'b1);
        clear_in();
        dx_valid = 1'b1; dx_rs_a = 5'd12;
        step("md_dest_new", 2'd0, 2'd0, 1'b1, 1'b1);
        dx_rs_a = 5'd9;
        step("md_dest_old", 2'd0, 2'd0, 1'b0, 1'b1);
        dx_valid = 1'b0; dx_rs_a = 5'd12;
        step("md_invalid", 2'd0, 2'd0, 1'b0, 1'b1);
        clear_in();
        md_ready = 1'b1;
        step("md_ready2", 2'd0, 2'd0, 1'b0, 1'b1);

        // Mult/div to r0: structural only
        clear_in();
        dx_valid = 1'b1; dx_is_md = 1'b1; dx_md_rd = 5'd0;
        step("rd0_issue", 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        dx_valid = 1'b1; dx_rs_a = 5'd1;
        step("rd0_nodata", 2'd0, 2'd0, 1'b0, 1'b1);
        dx_is_md = 1'b1;
        step("rd0_struct", 2'd0, 2'd0, 1'b1, 1'b1);
        clear_in();
        md_ready = 1'b1;
        step("rd0_ready", 2'd0, 2'd0, 1'b0, 1'b1);

        // md_ready while idle is ignored; load-use blocks an issue
        step("idle_ready", 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        dx_valid = 1'b1; dx_is_md = 1'b1; dx_md_rd = 5'd3;
        stg_lw = 1'b1; stg_we = 2'b01; stg_rd = {5'd0, 5'd2}; dx_rs_a = 5'd2;
        step("lu_blocks_issue", 2'd1, 2'd0, 1'b1, 1'b0);
        clear_in();
        step("no_issue_on_stall", 2'd0, 2'd0, 1'b0, 1'b0);

        // Clean reset, five stall cycles, then asynchronous reset mid-BUSY
        reset = 1'b0;
        #2;
        cmp("pulse_busy", 32'(md_busy), 32'd0);
`ifdef FWD_STALL_STATS_EN
        cmp("pulse_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b1;
        dx_valid = 1'b1; dx_is_md = 1'b1; dx_md_rd = 5'd4;
        step("cnt_issue", 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        dx_valid = 1'b1; dx_rs_a = 5'd4;
        for (int i = 0; i < 5; i++) begin
            step("cnt_stall", 2'd0, 2'd0, 1'b1, 1'b1);
        end
        expect_out("cnt_hold", 2'd0, 2'd0, 1'b1, 1'b1);
        @(negedge clock);
        check_all();
`ifdef FWD_STALL_STATS_EN
        cmp("cnt_five", stall_cnt, 32'd5);
`endif
        #2;
        reset = 1'b0;
        #1;
        expect_out("async_rst", 2'd0, 2'd0, 1'b0, 1'b0);
        check_all();
`ifdef FWD_STALL_STATS_EN
        cmp("cnt_cleared", stall_cnt, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_in();
        md_ready = 1'b1;
        step("late_ready", 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        dx_valid = 1'b1; dx_rs_a = 5'd4;
        step("after_abandon", 2'd0, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
